i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/sound_mixer_pkg.sv | 8 +
 rtl/i2s_transmitter_sck_divider.sv | 28 ++
 rtl/i2s_transmitter.sv | 90 +++++++++
 tb/tb_i2s_transmitter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sound_mixer_pkg.sv
// sound_mixer_pkg: shared sample type, channel encoding and default I2S timing constants
package sound_mixer_pkg;
    localparam int SAMPLE_W      = 24;
    localparam int CLK_DIV_DEF   = 4;
    localparam int SLOT_BITS_DEF = 32;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} chan_t;
endpackage

// File: rtl/i2s_transmitter_sck_divider.sv
// sck_divider: divides clk into sck and flags the clk cycle on which sck falls
module sck_divider
    import sound_mixer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic sck,
    output logic fall_evt
);
    logic [7:0] cnt;
    logic       tc;
    assign tc       = cnt == 8'(CLK_DIV - 1);
    assign fall_evt = tc & sck;
    // count 0..CLK_DIV-1, toggling sck and restarting at terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: 24-bit I2S serializer with a one-sample holding register.
// Define I2S_LEFT_JUSTIFIED_EN to move ws to the MSB (left-justified) instead of one sck earlier.
module i2s_transmitter
    import sound_mixer_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  sample_t in_data,
    input  logic    in_valid,
    output logic    in_ready,
    output logic    sck,
    output logic    ws,
    output logic    sd,
    output logic    underrun
);
    localparam int BW = $clog2(SLOT_BITS);

    if (SLOT_BITS < 24) begin : g_bad_slot_bits
        $error("SLOT_BITS must be at least 24");
    end
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("CLK_DIV must be in 2..255");
    end

    logic                fall_evt;
    logic                slot_start;
    logic                slot_end;
    logic                xfer;
    logic                hold_full;
    sample_t             hold;
    sample_t             load_word;
    logic [SAMPLE_W-1:0] shreg;
    logic [BW-1:0]       bit_idx;
    chan_t               chan;

    sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .fall_evt (fall_evt)
    );

    assign in_ready   = ~hold_full;
    assign xfer       = in_valid & in_ready;
    assign slot_start = fall_evt && bit_idx == '0;
    assign slot_end   = fall_evt && bit_idx == BW'(SLOT_BITS - 1);
    assign load_word  = hold_full ? hold : '0;

    // holding register: emptied at slot start, refilled by a transfer (transfer wins)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (slot_start) hold_full <= 1'b0;
            if (xfer) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

    // serializer: all ws/sd changes happen on sck falling events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx  <= '0;
            chan     <= CH_LEFT;
            shreg    <= '0;
            sd       <= 1'b0;
            ws       <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= slot_start & ~hold_full;
            if (fall_evt) begin
                bit_idx <= slot_end ? '0 : bit_idx + BW'(1);
                if (slot_end) chan <= chan == CH_LEFT ? CH_RIGHT : CH_LEFT;
                shreg <= slot_start ? {load_word[SAMPLE_W-2:0], 1'b0} : {shreg[SAMPLE_W-2:0], 1'b0};
                sd    <= slot_start ? load_word[SAMPLE_W-1] : shreg[SAMPLE_W-1];
`ifdef I2S_LEFT_JUSTIFIED_EN
                if (slot_start) ws <= chan == CH_RIGHT;
`else
                if (slot_end) ws <= chan == CH_LEFT;
`endif
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: randomized and directed checks of i2s_transmitter against a slot-level model
module tb_i2s_transmitter;
    import sound_mixer_pkg::*;
    localparam int CD = 2;
    localparam int SB = 32;
    localparam int P  = 2 * CD;

    logic    clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic    in_ready, sck, ws, sd, underrun;
    sample_t in_data = '0;
    int      checks = 0, errors = 0;

    always #5 clk = ~clk;

    i2s_transmitter #(.CLK_DIV(CD), .SLOT_BITS(SB)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd), .underrun(underrun)
    );

    int          n, ev, und_cnt, acc_cnt, slot_cnt, sck_rises;
    logic        m_held, m_und, sck_prev, pw, ps;
    sample_t     m_hold;
    logic [23:0] m_cur;
    logic [31:0] word;
    logic [31:0] words[$];
    logic        ws_q[$], ws_lead[$];
    sample_t     src[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ws();
        if (ev < 0) return 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
        return 1'((ev / SB) % 2);
`else
        return 1'(((ev + 1) / SB) % 2);
`endif
    endfunction

    function automatic logic exp_sd();
        int b;
        if (ev < 0) return 1'b0;
        b = ev % SB;
        return b < 24 ? m_cur[23-b] : 1'b0;
    endfunction

    task automatic step(input logic v, input sample_t d, output logic acc);
        logic rdy;
        in_valid = v;
        in_data  = d;
        rdy      = in_ready;
        acc      = v && !m_held;
        @(posedge clk);
        n++;
        m_und = 1'b0;
        if (n % P == 0) begin
            ev = n / P - 1;
            if (ev % SB == 0) begin
                if (v) chk("overlap", 32'(rdy & m_held), 0);
                m_cur  = m_held ? m_hold : '0;
                m_und  = !m_held;
                m_held = 1'b0;
                slot_cnt++;
            end
        end
        if (acc) begin
            m_hold = d;
            m_held = 1'b1;
            acc_cnt++;
        end
        @(negedge clk);
        chk("sck", 32'(sck), 32'((n / CD) % 2));
        chk("ws", 32'(ws), 32'(exp_ws()));
        chk("sd", 32'(sd), 32'(exp_sd()));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("in_ready", 32'(in_ready), 32'(!m_held));
        und_cnt += int'(underrun);
        if (sck && !sck_prev) sck_rises++;
        sck_prev = sck;
        if (ev >= 0 && n % P == 0) begin
            word = {word[30:0], sd};
            if (ev % SB == 0) ws_q.push_back(ws);
            if (ev % SB == SB - 1) begin
                ws_lead.push_back(ws);
                words.push_back(word);
                chk("word", word, {m_cur, 8'h00});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_sck", 32'(sck), 0);
        chk("rst_ws", 32'(ws), 0);
        chk("rst_sd", 32'(sd), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold_ready", 32'(in_ready), 1);
        chk("rst_hold_sck", 32'(sck), 0);
        reset = 1'b0;
        n = 0; ev = -1; m_held = 0; m_hold = '0; m_cur = '0; m_und = 0;
        word = '0; und_cnt = 0; acc_cnt = 0; slot_cnt = 0; sck_rises = 0; sck_prev = 0;
        words.delete(); ws_q.delete(); ws_lead.delete(); src.delete();
    endtask

    task automatic run(input int cycles, input int mode);
        logic a, v;
        sample_t d;
        for (int i = 0; i < cycles; i++) begin
            v = mode == 1 ? src.size() > 0 : mode == 2 ? $urandom_range(0, 99) < 30 : 1'b0;
            d = (mode == 1 && src.size() > 0) ? src[0] : sample_t'($urandom);
            step(v, d, a);
            if (a && mode == 1) void'(src.pop_front());
        end
    endtask

    task automatic run_until(input int target);
        logic a;
        for (int i = 0; i < 20000; i++) begin
            pw = ws;
            ps = sd;
            step(src.size() > 0, src.size() > 0 ? src[0] : '0, a);
            if (a) void'(src.pop_front());
            if (ev == target && n % P == 0) break;
        end
        chk("until", ev, target);
    endtask

    initial begin
        #2;
        // MSB-first framing and ws lead
        do_reset();
        src = '{sample_t'(24'h800001), sample_t'(24'h7FFFFE)};
        run(3 * SB * P, 1);
        chk("a_left", words[0], 32'h80000100);
        chk("a_right", words[1], 32'h7FFFFE00);
        chk("a_ws_right", 32'(ws_q[1]), 1);
`ifdef I2S_LEFT_JUSTIFIED_EN
        chk("a_ws_lead", 32'(ws_lead[0]), 0);
`else
        chk("a_ws_lead", 32'(ws_lead[0]), 1);
`endif
        // idle: underrun every slot, silent sd, sck period 4 clk
        do_reset();
        run(4 * SB * P, 0);
        chk("b_underruns", und_cnt, 4);
        chk("b_sck_rises", sck_rises, 128);
        for (int k = 0; k < 4; k++) chk("b_silent", words[k], 0);
        // continuous valid: strict alternation, in order
        do_reset();
        src = '{sample_t'(1), sample_t'(2), sample_t'(3), sample_t'(4)};
        run(5 * SB * P, 1);
        for (int k = 0; k < 4; k++) begin
            chk("c_word", words[k], 32'((k + 1) << 8));
            chk("c_chan", 32'(ws_q[k]), 32'(k % 2));
        end
        // reset mid right slot with a sample held
        do_reset();
        src = '{sample_t'(24'h11), sample_t'(24'h22), sample_t'(24'h33)};
        run_until(SB + 10);
        chk("d_held", 32'(in_ready), 0);
        do_reset();
        run(2 * SB * P, 0);
        chk("d_left_first", 32'(ws_q[0]), 0);
        chk("d_dropped0", words[0], 0);
        chk("d_dropped1", words[1], 0);
`ifdef I2S_LEFT_JUSTIFIED_EN
        // left-justified: ws and MSB change together
        do_reset();
        src = '{sample_t'(0), sample_t'(24'hA00000)};
        run_until(SB);
        chk("lj_edge", {28'h0, pw, ps, ws, sd}, 32'h3);
`endif
        // random 30% valid
        do_reset();
        run(400 * SB * P, 2);
        chk("e_underruns", und_cnt, slot_cnt - (acc_cnt - int'(m_held)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
